// File: rtl/alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: FSM state encoding and
// the op codes understood by the external 1-bit ALU.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

endpackage

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU, LSB first, WIDTH cycles per op.
// Optional feature: define ALU_SEQ_ABORT_EN to add the abort input.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALU_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [1:0]       alu_ctrl,
    output logic             alu_a,
    output logic             alu_b,
    input  logic             alu_y,
    input  logic             alu_z
);

    import alu_seq_pkg::*;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              abort_w;

`ifdef ALU_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // NOTE: every next-state signal gets its default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                // Abort outranks a simultaneous start.
                if (start && !abort_w) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    result_d = '0;
                    zero_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_w) begin
                    // Leave result/zero at their cleared start-of-operation values.
                    result_d = '0;
                    zero_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    result_d = {alu_y, result_q[WIDTH-1:1]};
                    a_d      = a_q >> 1;
                    b_d      = b_q >> 1;
                    zero_d   = zero_q & alu_z;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign zero     = zero_q;
    assign alu_ctrl = op_q;
    assign alu_a    = busy & a_q[0];
    assign alu_b    = busy & b_q[0];

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed, table-driven bench for alu_serial_seq with a behavioural 1-bit ALU.
// Abort scenarios are compiled in only when ALU_SEQ_ABORT_EN is defined.
module tb_alu_serial_seq;

    import alu_seq_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [1:0]       alu_ctrl;
    logic             alu_a;
    logic             alu_b;
    logic             alu_y;
    logic             alu_z;
`ifdef ALU_SEQ_ABORT_EN
    logic             abort;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_r;
        logic             exp_z;
    } vec_t;

    vec_t vecs[9];

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
`ifdef ALU_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .alu_ctrl (alu_ctrl),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .alu_z    (alu_z)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_XOR:  alu_y = alu_a ^ alu_b;
            default: alu_y = ~(alu_a ^ alu_b);
        endcase
        alu_z = ~alu_y;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_exclusive", 32'(busy & done), 32'd0);
            if (!busy) check("alu_ab_idle_zero", 32'({alu_a, alu_b}), 32'd0);
        end
    end

    // Caller guarantees the DUT is idle. Leaves the DUT idle on return.
    task automatic run_op(input vec_t v, input bit scramble, input string tag);
        int busy_cnt = 0;
        int done_cyc = 0;
        op = v.op; a = v.a; b = v.b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) begin
            a = '0; b = '0; op = OP_AND;
        end
        for (int c = 1; c <= WIDTH + 3; c++) begin
            if (busy) busy_cnt++;
            if (done && done_cyc == 0) begin
                done_cyc = c;
                check({tag, "_result"}, 32'(result), 32'(v.exp_r));
                check({tag, "_zero"}, 32'(zero), 32'(v.exp_z));
            end
            @(posedge clk); #1;
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(WIDTH + 1));
        check({tag, "_result_held"}, 32'(result), 32'(v.exp_r));
        check({tag, "_zero_held"}, 32'(zero), 32'(v.exp_z));
    endtask

    initial begin
        int ndone;
        int last_c;
        vec_t v;

        vecs[0] = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1] = '{OP_XOR,  8'h5A, 8'h5A, 8'h00, 1'b1};
        vecs[2] = '{OP_XNOR, 8'h5A, 8'h5A, 8'hFF, 1'b0};
        vecs[3] = '{OP_OR,   8'h0F, 8'hF0, 8'hFF, 1'b0};
        vecs[4] = '{OP_AND,  8'h55, 8'hAA, 8'h00, 1'b1};
        vecs[5] = '{OP_OR,   8'h00, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{OP_XOR,  8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[7] = '{OP_XNOR, 8'h00, 8'h00, 8'hFF, 1'b0};
        vecs[8] = '{OP_AND,  8'h81, 8'hFF, 8'h81, 1'b0};

        rst = 1'b1; start = 1'b0; op = OP_XNOR; a = '1; b = '1;
`ifdef ALU_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
        rst = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start_busy", 32'(busy), 32'd0);
        check("idle_no_start_done", 32'(done), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_alu_ctrl_held", i), 32'(alu_ctrl), 32'(vecs[i].op));
        end

        // Operands scrambled right after acceptance must not disturb the op in flight.
        v = '{OP_OR, 8'h0F, 8'hF0, 8'hFF, 1'b0};
        run_op(v, 1'b1, "scramble");

        // Start held high: one accept every WIDTH+2 cycles, mid-op starts ignored.
        op = OP_OR; a = 8'h01; b = 8'h80; start = 1'b1;
        ndone = 0; last_c = 0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check("cont_result", 32'(result), 32'h81);
                if (ndone > 1) check("cont_interval", 32'(c - last_c), 32'(WIDTH + 2));
                last_c = c;
            end
        end
        check("cont_done_count", 32'(ndone), 32'd3);
        start = 1'b0;
        repeat (WIDTH + 4) @(posedge clk);
        #1;
        check("cont_drained", 32'(busy | done), 32'd0);

        // Reset in the 4th SHIFT cycle aborts with no done pulse.
        op = OP_AND; a = 8'hAA; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_zero", 32'(zero), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("midrst_no_activity", 32'(ndone), 32'd0);
        v = '{OP_AND, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        run_op(v, 1'b0, "post_rst");

`ifdef ALU_SEQ_ABORT_EN
        // Abort in the 2nd SHIFT cycle.
        op = OP_OR; a = 8'h0F; b = 8'hF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        ndone = 0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        // Abort and start together in IDLE: abort wins.
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        check("abort_beats_start", 32'(busy), 32'd0);

        v = '{OP_XOR, 8'hC3, 8'h0F, 8'hCC, 1'b0};
        run_op(v, 1'b0, "post_abort");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
